// File: rtl/hash_target_checker_if.sv
// Hash-checker signal bundle: batch/nonce inputs, lane digests, result handshake and statistics.
// master drives hash results and consumes found entries; slave is the checker side.
interface hash_target_checker_if #(
  parameter int LANES   = 2,
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 6
);
  logic [CNT_W-1:0]    count;
  logic [NONCE_W-1:0]  nonce;
  logic                clear;
  logic                hash_valid;
  logic [LANES*32-1:0] hash_hi;
  logic [5:0]          target_zeros;
  logic                found_valid;
  logic [NONCE_W-1:0]  found_nonce;
  logic                found_ready;
  logic                overflow;
  logic [15:0]         match_cnt;
  logic [15:0]         hash_cnt;

  modport master (
    output count, nonce, clear, hash_valid, hash_hi, target_zeros, found_ready,
    input  found_valid, found_nonce, overflow, match_cnt, hash_cnt
  );

  modport slave (
    input  count, nonce, clear, hash_valid, hash_hi, target_zeros, found_ready,
    output found_valid, found_nonce, overflow, match_cnt, hash_cnt
  );
endinterface

// File: rtl/hash_target_checker.sv
// Leading-zero target check on LANES digests, matches queued in a multi-push FIFO; 1-cycle latency.
// found_valid/found_ready pops the head; excess matches are dropped with sticky overflow. Stats: HASH_CHECK_STATS_EN.
module hash_target_checker #(
  parameter int LANES      = 2,
  parameter int NONCE_W    = 32,
  parameter int CNT_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  hash_target_checker_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [NONCE_W-1:0] nonce_stored_q, nonce_stored_d;
  logic [NONCE_W-1:0] mem_q [FIFO_DEPTH];
  logic [NONCE_W-1:0] last_q;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      occ_q, occ_d, free_slots, n_push;
  logic               ovf_q, ovf_d;

  logic [LANES-1:0]   wr_en;
  logic [PW-1:0]      wr_idx [LANES];
  logic [NONCE_W-1:0] wr_dat [LANES];
  logic [5:0]         tz_eff;
  logic [31:0]        zmask;
  logic               pop, drop;

  always_comb begin
    tz_eff     = (bus.target_zeros > 6'd32) ? 6'd32 : bus.target_zeros;
    zmask      = ~(32'hFFFF_FFFF >> tz_eff);
    pop        = (occ_q != '0) && bus.found_ready && !bus.clear;
    free_slots = CW'(FIFO_DEPTH) - occ_q + CW'(pop);
    n_push     = '0;
    drop       = 1'b0;
    // Lanes claim free slots in ascending order; later lanes are the ones dropped.
    for (int i = 0; i < LANES; i++) begin
      wr_en[i]  = 1'b0;
      wr_idx[i] = wr_ptr_q + n_push[PW-1:0];
      wr_dat[i] = nonce_stored_q + NONCE_W'(i);
      if (bus.hash_valid && !bus.clear && ((bus.hash_hi[32*i +: 32] & zmask) == 32'd0)) begin
        if (n_push < free_slots) begin
          wr_en[i] = 1'b1;
          n_push   = n_push + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end

    nonce_stored_d = (bus.count == CNT_W'(0)) ? bus.nonce : nonce_stored_q;

    if (bus.clear) begin
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      occ_d    = occ_q + n_push - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
      ovf_d    = ovf_q | drop;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nonce_stored_q <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      occ_q          <= '0;
      ovf_q          <= 1'b0;
      last_q         <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      nonce_stored_q <= nonce_stored_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      occ_q          <= occ_d;
      ovf_q          <= ovf_d;
      // Remember the head so an emptied FIFO keeps presenting the last value seen.
      if (occ_q != '0) last_q <= mem_q[rd_ptr_q];
      for (int i = 0; i < LANES; i++) begin
        if (wr_en[i]) mem_q[wr_idx[i]] <= wr_dat[i];
      end
    end
  end

  assign bus.found_valid = (occ_q != '0);
  assign bus.found_nonce = (occ_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign bus.overflow    = ovf_q;

`ifdef HASH_CHECK_STATS_EN
  logic [15:0] match_cnt_q, match_cnt_d, hash_cnt_q, hash_cnt_d;
  logic [16:0] match_sum;

  always_comb begin
    match_sum   = {1'b0, match_cnt_q} + 17'(n_push);
    match_cnt_d = match_sum[16] ? 16'hFFFF : match_sum[15:0];
    hash_cnt_d  = (bus.hash_valid && hash_cnt_q != 16'hFFFF) ? hash_cnt_q + 16'd1 : hash_cnt_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      match_cnt_q <= '0;
      hash_cnt_q  <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      hash_cnt_q  <= hash_cnt_d;
    end
  end

  assign bus.match_cnt = match_cnt_q;
  assign bus.hash_cnt  = hash_cnt_q;
`else
  assign bus.match_cnt = '0;
  assign bus.hash_cnt  = '0;
`endif
endmodule
